rom_download_ctrl: RTL

- Sequences the HPS ROM download stream into the Scramble core's ROM regions: CPU program, sound CPU, graphics and colour PROM.
- Decodes each download byte into exactly one region write strobe with a region-relative address.
- Checks that the image is complete.
- Owns the core reset: holds it through the download and for a fixed settle time afterwards, then releases it; also sequences user resets.

---
 rtl/rom_download_ctrl_if.sv | 11 +
 rtl/rom_download_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rom_download_ctrl_if.sv
// HPS ioctl download bus: level-qualified byte stream with a one-cycle write strobe.
// The HPS side drives it (master); the ROM download controller receives it (slave).
interface rom_download_ctrl_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    modport master (output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout);
    modport slave  (input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout);
endinterface

// File: rtl/rom_download_ctrl.sv
// Routes the HPS ROM download into the Scramble CPU/sound/graphics/PROM regions,
// checks the image for completeness, and owns the core reset.
//
// state   | meaning
// S_IDLE  | no download seen since reset, core held in reset
// S_LOAD  | download active, bytes decoded into region write strobes
// S_HOLD  | image good or user reset, core held for HOLD_CYCLES
// S_RUN   | core released
// S_FAULT | bad image, core held until the next download
module rom_download_ctrl #(
    parameter int unsigned CPU_SIZE    = 16384,
    parameter int unsigned SND_SIZE    = 8192,
    parameter int unsigned GFX_SIZE    = 4096,
    parameter int unsigned PROM_SIZE   = 32,
    parameter int unsigned HOLD_CYCLES = 1024
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    rom_download_ctrl_if.slave ioctl,
    input  logic               user_reset,
    output logic [15:0]        rom_addr,
    output logic [7:0]         rom_data,
    output logic               cpu_we,
    output logic               snd_we,
    output logic               gfx_we,
    output logic               prom_we,
    output logic               core_reset,
    output logic               dl_done,
    output logic               dl_error,
    output logic [15:0]        byte_count
);
    localparam logic [24:0] SND_BASE  = 25'(CPU_SIZE);
    localparam logic [24:0] GFX_BASE  = 25'(CPU_SIZE + SND_SIZE);
    localparam logic [24:0] PROM_BASE = 25'(CPU_SIZE + SND_SIZE + GFX_SIZE);
    localparam logic [24:0] TOTAL     = 25'(CPU_SIZE + SND_SIZE + GFX_SIZE + PROM_SIZE);
    localparam int unsigned HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_FAULT} state_t;

    state_t        state_q;
    logic          dl_q;
    logic          ur_q;
    logic [HW-1:0] hold_q;
    logic [3:0]    we_q;
    logic [15:0]   rom_addr_q;
    logic [7:0]    rom_data_q;
    logic          core_reset_q;
    logic          dl_done_q;
    logic          dl_error_q;
    logic [15:0]   byte_count_q;

    logic          rise;
    logic          fall;
    logic          wr_load;
    logic          in_range;
    logic          accept;
    logic [3:0]    sel;
    logic [24:0]   base;
    logic [15:0]   offset;
    logic [15:0]   byte_count_d;
    logic          dl_error_d;
    logic          fault_d;

    always_comb begin
        rise     = ioctl.ioctl_download & ~dl_q;
        fall     = ~ioctl.ioctl_download & dl_q;
        wr_load  = ioctl.ioctl_wr && (state_q == S_LOAD);
        in_range = ioctl.ioctl_addr < TOTAL;
        accept   = wr_load && in_range;
        sel      = 4'b0000;
        base     = '0;
        if (ioctl.ioctl_addr < SND_BASE) begin
            sel = 4'b1000;
        end else if (ioctl.ioctl_addr < GFX_BASE) begin
            sel  = 4'b0100;
            base = SND_BASE;
        end else if (ioctl.ioctl_addr < PROM_BASE) begin
            sel  = 4'b0010;
            base = GFX_BASE;
        end else begin
            sel  = 4'b0001;
            base = PROM_BASE;
        end
        offset       = 16'(ioctl.ioctl_addr - base);
        byte_count_d = byte_count_q;
        if (accept && (byte_count_q != 16'hFFFF)) begin
            byte_count_d = byte_count_q + 16'd1;
        end
        dl_error_d = dl_error_q | (wr_load & ~in_range);
        // A strobe landing on the fall cycle is counted before the image check.
        fault_d    = dl_error_d || ({9'd0, byte_count_d} != TOTAL);
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            dl_q         <= 1'b1;
            ur_q         <= 1'b0;
            hold_q       <= '0;
            we_q         <= 4'b0000;
            rom_addr_q   <= '0;
            rom_data_q   <= '0;
            core_reset_q <= 1'b1;
            dl_done_q    <= 1'b0;
            dl_error_q   <= 1'b0;
            byte_count_q <= '0;
        end else begin
            dl_q         <= ioctl.ioctl_download;
            ur_q         <= user_reset;
            we_q         <= accept ? sel : 4'b0000;
            core_reset_q <= !((state_q == S_RUN) && !user_reset && !rise);
            if (accept) begin
                rom_addr_q <= offset;
                rom_data_q <= ioctl.ioctl_dout;
            end
            case (state_q)
                S_LOAD: begin
                    byte_count_q <= byte_count_d;
                    dl_error_q   <= dl_error_d;
                    if (fall) begin
                        if (fault_d) begin
                            state_q    <= S_FAULT;
                            dl_error_q <= 1'b1;
                        end else begin
                            state_q <= S_HOLD;
                            hold_q  <= '0;
                        end
                    end
                end
                S_HOLD: begin
                    // Hold time restarts from the cycle the user request drops.
                    if (user_reset || ur_q) begin
                        hold_q <= '0;
                    end else if (hold_q == HOLD_LAST) begin
                        state_q   <= S_RUN;
                        dl_done_q <= 1'b1;
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                S_RUN: begin
                    if (user_reset) begin
                        state_q <= S_HOLD;
                        hold_q  <= '0;
                    end
                end
                default: ;
            endcase
            if (rise) begin
                state_q      <= S_LOAD;
                byte_count_q <= '0;
                dl_error_q   <= 1'b0;
                dl_done_q    <= 1'b0;
            end
        end
    end

    assign {cpu_we, snd_we, gfx_we, prom_we} = we_q;
    assign rom_addr   = rom_addr_q;
    assign rom_data   = rom_data_q;
    assign core_reset = core_reset_q;
    assign dl_done    = dl_done_q;
    assign dl_error   = dl_error_q;
    assign byte_count = byte_count_q;
endmodule
